// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR multiply-accumulate sequencer.
//   - Default parameter constants for sample, tap and accumulator widths.
//   - Sequencer state enumeration.
package fir_pkg;

    localparam int unsigned DEF_DATA_IN_WIDTH = 16;
    localparam int unsigned DEF_TAP_WIDTH     = 24;
    localparam int unsigned DEF_TAP_COUNT     = 36;
    localparam int unsigned DEF_ACC_WIDTH     = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: registered signed multiply-accumulate.
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   clr_i        : synchronous clear of the accumulator (wins over en_i)
//   en_i         : accumulate a_i*b_i on this edge
//   a_i, b_i     : signed operands
//   acc_o        : registered accumulator, wraps modulo 2^ACC_W
module fir_mac_unit #(
    parameter int unsigned A_W   = 16,
    parameter int unsigned B_W   = 24,
    parameter int unsigned ACC_W = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam int unsigned P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // Full-precision product, sign-extended to the accumulator width.
    assign prod     = a_i * b_i;
    assign prod_ext = {{(ACC_W - P_W){prod[P_W-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR filter, one multiply-accumulate per cycle.
//   clk, reset_n       : clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready    : input sample handshake, s_data signed sample
//   coef_we/coef_addr/coef_data : coefficient write port, accepted only in IDLE
//   coef_err           : one-cycle pulse after a rejected coefficient write
//   m_valid/m_ready    : result handshake, m_data signed filter result
//   busy               : high whenever the sequencer is not IDLE
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned DATA_IN_WIDTH = DEF_DATA_IN_WIDTH,
    parameter int unsigned TAP_WIDTH     = DEF_TAP_WIDTH,
    parameter int unsigned TAP_COUNT     = DEF_TAP_COUNT,
    parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic signed [DATA_IN_WIDTH-1:0] s_data,
    input  logic                            coef_we,
    input  logic [$clog2(TAP_COUNT)-1:0]    coef_addr,
    input  logic signed [TAP_WIDTH-1:0]     coef_data,
    output logic                            coef_err,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic signed [ACC_WIDTH-1:0]     m_data,
    output logic                            busy
);

    localparam int unsigned PTR_W = $clog2(TAP_COUNT);
    localparam int unsigned K_W   = $clog2(TAP_COUNT + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TAP_COUNT - 1);
    localparam logic [K_W-1:0]   K_DONE   = K_W'(TAP_COUNT);

    fir_state_e state_q, state_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [K_W-1:0]   k_q, k_d;
    logic signed [ACC_WIDTH-1:0] m_data_q, m_data_d;
    logic coef_err_q, coef_err_d;

    logic signed [DATA_IN_WIDTH-1:0] smp_q  [TAP_COUNT];
    logic signed [TAP_WIDTH-1:0]     coef_q [TAP_COUNT];

    logic accept, mac_en, load_out, coef_ok;
    logic signed [DATA_IN_WIDTH-1:0] smp_rd;
    logic signed [TAP_WIDTH-1:0]     coef_rd;
    logic signed [ACC_WIDTH-1:0]     acc;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // MAC spends TAP_COUNT cycles accumulating (k = 0..TAP_COUNT-1) plus one
    // final cycle at k == TAP_COUNT that moves the settled sum into m_data.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (s_valid)          state_d = ST_MAC;
            ST_MAC:  if (k_q == K_DONE)    state_d = ST_OUT;
            ST_OUT:  if (m_ready)          state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / controls ----------------
    always_comb begin
        s_ready  = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
        m_valid  = (state_q == ST_OUT);
        accept   = (state_q == ST_IDLE) && s_valid;
        mac_en   = (state_q == ST_MAC) && (k_q != K_DONE);
        load_out = (state_q == ST_MAC) && (k_q == K_DONE);
        coef_ok  = coef_we && (state_q == ST_IDLE) && (32'(coef_addr) < TAP_COUNT);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        k_d        = k_q;
        m_data_d   = m_data_q;
        coef_err_d = coef_we && !coef_ok;
        if (accept) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            // The sample written this edge is the newest, so reading starts there.
            rd_ptr_d = wr_ptr_q;
            k_d      = '0;
        end else if (mac_en) begin
            rd_ptr_d = (rd_ptr_q == '0) ? LAST_PTR : rd_ptr_q - 1'b1;
            k_d      = k_q + 1'b1;
        end
        if (load_out) begin
            m_data_d = acc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            k_q        <= '0;
            m_data_q   <= '0;
            coef_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            k_q        <= k_d;
            m_data_q   <= m_data_d;
            coef_err_q <= coef_err_d;
        end
    end

    // ---------------- circular sample buffer ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < TAP_COUNT; i++) begin
                smp_q[i] <= '0;
            end
        end else if (accept) begin
            smp_q[wr_ptr_q] <= s_data;
        end
    end

    // ---------------- coefficient storage ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < TAP_COUNT; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_ok) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    assign smp_rd  = smp_q[rd_ptr_q];
    assign coef_rd = coef_q[k_q[PTR_W-1:0]];

    fir_mac_unit #(
        .A_W   (DATA_IN_WIDTH),
        .B_W   (TAP_WIDTH),
        .ACC_W (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (accept),
        .en_i    (mac_en),
        .a_i     (smp_rd),
        .b_i     (coef_rd),
        .acc_o   (acc)
    );

    assign m_data   = m_data_q;
    assign coef_err = coef_err_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

    localparam int N  = 36;
    localparam int DW = 16;
    localparam int TW = 24;
    localparam int AW = 64;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] s_data = '0;
    logic                 coef_we = 1'b0;
    logic [5:0]           coef_addr = '0;
    logic signed [TW-1:0] coef_data = '0;
    logic                 coef_err;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic signed [AW-1:0] m_data;
    logic                 busy;

    fir_mac_sequencer #(
        .DATA_IN_WIDTH (DW),
        .TAP_WIDTH     (TW),
        .TAP_COUNT     (N),
        .ACC_WIDTH     (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_err  (coef_err),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: coefficient table and full sample history (oldest first).
    longint mc [N];
    longint hist [$];

    function automatic longint model_out();
        longint s = 0;
        for (int k = 0; k < N; k++) begin
            if (k < hist.size()) s += mc[k] * hist[hist.size() - 1 - k];
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mc[i] = 0;
        hist.delete();
    endtask

    task automatic apply_reset();
        s_valid = 1'b0; coef_we = 1'b0; m_ready = 1'b0;
        s_data = '0; coef_addr = '0; coef_data = '0;
        reset_n = 1'b0;
        #23;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Single coefficient write issued from IDLE.
    task automatic write_coef(input int a, input longint v);
        coef_we = 1'b1; coef_addr = 6'(a); coef_data = TW'(v);
        @(posedge clk); #1;
        coef_we = 1'b0;
        if (a < N) mc[a] = longint'(coef_data);
    endtask

    // Present one sample (optionally with a same-edge coefficient write), wait for m_valid.
    task automatic run_sample(input logic signed [DW-1:0] x, input bit wcoef, input int wa,
                              input longint wv, output longint res, output int lat, output bit to);
        int w;
        to = 1'b0; lat = 0; res = 0; w = 0;
        s_valid = 1'b1; s_data = x;
        while (!s_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (!s_ready) to = 1'b1;
        if (!to) begin
            if (wcoef) begin coef_we = 1'b1; coef_addr = 6'(wa); coef_data = TW'(wv); end
            @(posedge clk); #1;
            s_valid = 1'b0;
            coef_we = 1'b0;
            if (wcoef && wa < N) mc[wa] = longint'(coef_data);
            hist.push_back(longint'(x));
            while (!m_valid && lat < 200) begin @(posedge clk); #1; lat++; end
            if (!m_valid) to = 1'b1;
            else res = longint'(m_data);
        end
        s_valid = 1'b0;
    endtask

    task automatic pop_result();
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_m_data got=%0d exp=0", m_data); end
        checks++; if (coef_err !== 1'b0) begin failures++; $display("FAIL reset_coef_err got=%0b exp=0", coef_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_impulse();
        longint res, exp; int lat; bit to;
        apply_reset();
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        for (int i = 0; i < N; i++) begin
            run_sample((i == 0) ? 16'sd1 : 16'sd0, 1'b0, 0, 0, res, lat, to);
            exp = model_out();
            checks++; if (to) begin failures++; $display("FAIL impulse_timeout idx=%0d", i); end
            checks++; if (res !== exp || res !== longint'(i + 1)) begin failures++; $display("FAIL impulse_result idx=%0d got=%0d exp=%0d", i, res, exp); end
            checks++; if (lat !== N + 1) begin failures++; $display("FAIL impulse_latency idx=%0d got=%0d exp=%0d", i, lat, N + 1); end
            pop_result();
        end
    endtask

    task automatic test_back_pressure();
        longint res, exp; int lat; bit to;
        logic signed [DW-1:0] y;
        run_sample(DW'($urandom), 1'b0, 0, 0, res, lat, to);
        exp = model_out();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL bp_first got=%0d exp=%0d to=%0b", res, exp, to); end
        // Offer the next sample while the result is held: it must not be consumed.
        y = DW'($urandom);
        s_valid = 1'b1; s_data = y;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== res || s_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d m_valid=%0b m_data=%0d exp_data=%0d s_ready=%0b busy=%0b", i, m_valid, m_data, res, s_ready, busy);
            end
            @(posedge clk); #1;
        end
        pop_result();
        checks++; if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("FAIL bp_idle s_ready=%0b busy=%0b m_valid=%0b exp=1,0,0", s_ready, busy, m_valid); end
        run_sample(y, 1'b0, 0, 0, res, lat, to);
        exp = model_out();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL bp_pending got=%0d exp=%0d to=%0b", res, exp, to); end
        pop_result();
    endtask

    task automatic test_coef_reject();
        longint res, exp; int lat; bit to;
        logic signed [DW-1:0] x;
        write_coef(2, 77);
        checks++; if (coef_err !== 1'b0) begin failures++; $display("FAIL coef_ok_err got=%0b exp=0", coef_err); end
        x = DW'($urandom);
        s_valid = 1'b1; s_data = x;
        @(posedge clk); #1;
        s_valid = 1'b0;
        hist.push_back(longint'(x));
        repeat (3) begin @(posedge clk); #1; end
        coef_we = 1'b1; coef_addr = 6'd5; coef_data = 24'sh7FFFFF;
        @(posedge clk); #1;
        coef_we = 1'b0;
        checks++; if (coef_err !== 1'b1) begin failures++; $display("FAIL coef_mac_err_pulse got=%0b exp=1", coef_err); end
        @(posedge clk); #1;
        checks++; if (coef_err !== 1'b0) begin failures++; $display("FAIL coef_mac_err_clear got=%0b exp=0", coef_err); end
        lat = 0;
        while (!m_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        exp = model_out();
        checks++; if (m_valid !== 1'b1 || m_data !== exp) begin failures++; $display("FAIL coef_mac_result got=%0d exp=%0d valid=%0b", m_data, exp, m_valid); end
        pop_result();
        write_coef(40, 999);
        checks++; if (coef_err !== 1'b1) begin failures++; $display("FAIL coef_range_err_pulse got=%0b exp=1", coef_err); end
        @(posedge clk); #1;
        checks++; if (coef_err !== 1'b0) begin failures++; $display("FAIL coef_range_err_clear got=%0b exp=0", coef_err); end
        run_sample(DW'($urandom), 1'b0, 0, 0, res, lat, to);
        exp = model_out();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL coef_range_result got=%0d exp=%0d to=%0b", res, exp, to); end
        pop_result();
    endtask

    task automatic test_wraparound();
        longint res, exp; int lat; bit to;
        apply_reset();
        for (int k = 0; k < N; k++) write_coef(k, 1);
        for (int i = 0; i < 40; i++) begin
            run_sample(16'sd2, 1'b0, 0, 0, res, lat, to);
            exp = model_out();
            checks++;
            if (to || res !== exp || res !== 2 * longint'((i + 1 < N) ? i + 1 : N)) begin
                failures++; $display("FAIL wrap_result idx=%0d got=%0d exp=%0d to=%0b", i, res, exp, to);
            end
            pop_result();
        end
    endtask

    task automatic test_extreme();
        longint res, exp; int lat; bit to;
        apply_reset();
        for (int k = 0; k < N; k++) write_coef(k, -64'sd8388608);
        for (int i = 0; i < N; i++) begin
            run_sample(-16'sd32768, 1'b0, 0, 0, res, lat, to);
            exp = model_out();
            checks++; if (to || res !== exp) begin failures++; $display("FAIL extreme_result idx=%0d got=%0d exp=%0d to=%0b", i, res, exp, to); end
            pop_result();
        end
        checks++; if (res !== (64'sd36 <<< 38)) begin failures++; $display("FAIL extreme_final got=%0d exp=%0d", res, 64'sd36 <<< 38); end
    endtask

    task automatic test_random();
        longint res, exp; int lat; bit to;
        logic signed [TW-1:0] cv;
        bit wc; int wa; int hold;
        apply_reset();
        for (int k = 0; k < N; k++) begin cv = TW'($urandom); write_coef(k, longint'(cv)); end
        for (int i = 0; i < 60; i++) begin
            wc = ($urandom_range(0, 3) == 0);
            wa = $urandom_range(0, N - 1);
            cv = TW'($urandom);
            run_sample(DW'($urandom), wc, wa, longint'(cv), res, lat, to);
            exp = model_out();
            checks++; if (to || res !== exp) begin failures++; $display("FAIL random_result idx=%0d got=%0d exp=%0d to=%0b", i, res, exp, to); end
            checks++; if (lat !== N + 1) begin failures++; $display("FAIL random_latency idx=%0d got=%0d exp=%0d", i, lat, N + 1); end
            hold = $urandom_range(0, 3);
            repeat (hold) begin @(posedge clk); #1; end
            pop_result();
        end
    endtask

    task automatic test_reset_mid_mac();
        longint res, exp; int lat; bit to; bit seen;
        logic signed [TW-1:0] cv;
        s_valid = 1'b1; s_data = 16'sd1234;
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || m_data !== '0) begin failures++; $display("FAIL midmac_async busy=%0b m_valid=%0b m_data=%0d exp=0,0,0", busy, m_valid, m_data); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin @(posedge clk); #1; if (m_valid) seen = 1'b1; end
        checks++; if (seen) begin failures++; $display("FAIL midmac_no_valid got=1 exp=0"); end
        run_sample(16'sd1, 1'b0, 0, 0, res, lat, to);
        exp = model_out();
        checks++; if (to || res !== exp || res !== 0) begin failures++; $display("FAIL midmac_impulse got=%0d exp=%0d to=%0b", res, exp, to); end
        pop_result();
        for (int k = 0; k < N; k++) begin cv = TW'($urandom); write_coef(k, longint'(cv)); end
        run_sample(16'sd0, 1'b0, 0, 0, res, lat, to);
        exp = model_out();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL midmac_buffer got=%0d exp=%0d to=%0b", res, exp, to); end
        pop_result();
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_back_pressure();
        test_coef_reject();
        test_wraparound();
        test_extreme();
        test_random();
        test_reset_mid_mac();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 16, signed input sample width.
REQ-002 SHALL have parameter TAP_WIDTH, default 24, signed coefficient width.
REQ-003 SHALL have parameter TAP_COUNT, default 36, number of taps (>=2).
REQ-004 SHALL have parameter ACC_WIDTH, default 64, accumulator and output width.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port s_valid  input  1  input sample valid.
REQ-008 SHALL have port s_ready  output  1  sequencer can accept a sample.
REQ-009 SHALL have port s_data  input  DATA_IN_WIDTH  signed input sample.
REQ-010 SHALL have port coef_we  input  1  coefficient write strobe.
REQ-011 SHALL have port coef_addr  input  $clog2(TAP_COUNT)  tap index.
REQ-012 SHALL have port coef_data  input  TAP_WIDTH  signed coefficient value.
REQ-013 SHALL have port coef_err  output  1  one-cycle pulse, rejected coefficient write.
REQ-014 SHALL have port m_valid  output  1  filter result valid.
REQ-015 SHALL have port m_ready  input  1  downstream accepts result.
REQ-016 SHALL have port m_data  output  ACC_WIDTH  signed filter result.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, MAC, OUT; s_ready = 1 only in IDLE.
REQ-019 In IDLE, a cycle with s_valid&&s_ready SHALL write s_data to the circular sample buffer at wr_ptr, clear the accumulator, set tap index k=0, and enter MAC.
REQ-020 wr_ptr SHALL advance by one per accepted sample, wrapping TAP_COUNT-1 -> 0.
REQ-021 In MAC, each cycle SHALL perform exactly one multiply-accumulate: acc += x[n-k]*c[k], where x[n-k] is read from the buffer entry k positions behind the newest sample (modulo TAP_COUNT); k increments.
REQ-022 After the MAC with k=TAP_COUNT-1, the FSM SHALL register the sum into m_data and enter OUT; m_valid SHALL rise exactly TAP_COUNT+1 cycles after the accepting edge.
REQ-023 Result SHALL equal sum over k=0..TAP_COUNT-1 of c[k]*x[n-k], with samples older than the first post-reset sample taken as 0.
REQ-024 Products SHALL be full precision (DATA_IN_WIDTH+TAP_WIDTH, signed); accumulation SHALL sign-extend to ACC_WIDTH and wrap modulo 2^ACC_WIDTH.
REQ-025 In OUT, m_valid SHALL be 1 and m_data SHALL hold stable until m_valid&&m_ready; on that edge the FSM SHALL return to IDLE.
REQ-026 s_valid asserted outside IDLE SHALL not be consumed; the sample stays pending upstream.
REQ-027 A coef_we in IDLE with coef_addr < TAP_COUNT SHALL write c[coef_addr] on that edge.
REQ-028 A coef_we in MAC or OUT, or with coef_addr >= TAP_COUNT, SHALL be ignored and SHALL pulse coef_err high for the next cycle.
REQ-029 Simultaneous coef_we and sample acceptance in IDLE SHALL apply the coefficient write first; the new value is used by that sample's computation.

Reset
REQ-030 On reset_n low, asynchronously: state=IDLE, wr_ptr=0, k=0, acc=0, all sample buffer entries=0, all coefficients=0.
REQ-031 Reset values of outputs SHALL be s_ready=1 once reset_n deasserts, m_valid=0, m_data=0, coef_err=0, busy=0.
REQ-032 Reset asserted mid-MAC or in OUT SHALL abort the computation; no m_valid is produced for that sample.

Structure
REQ-033 Package fir_pkg SHALL hold the state enum type and default parameter constants.
REQ-034 Sub-module fir_mac_unit (registered signed multiply-accumulate with synchronous clear and enable) SHALL contain the arithmetic; the sequencer owns FSM, buffer, coefficient storage.

Verification
REQ-035 Impulse: c[k]=k+1, send 1 then 35 zeros -> outputs 1,2,...,36, each m_valid exactly 37 cycles after its acceptance.
REQ-036 Back-pressure: m_ready held 0 for 10 cycles in OUT -> m_data stable, s_ready=0, busy=1; result accepted on the 11th cycle, FSM returns to IDLE.
REQ-037 Coefficient reject: coef_we during MAC, and coef_addr=40 in IDLE -> coef_err pulses once each, coefficients unchanged.
REQ-038 Wrap-around: c[all]=1, send 40 samples of value 2 -> after wr_ptr wraps, results saturate at 72 from sample 36 on.
REQ-039 Extreme values: c[all]=-2^23, samples -2^15 -> result 36*2^38 exactly, no overflow in 64 bits.
REQ-040 Reset mid-MAC at k=10 -> no m_valid, buffer and coefficients zero, next impulse sample yields result 0.
